// File: rtl/stopwatch_counter_if.sv
// stopwatch_counter_if: groups the tick/control inputs and the MM:SS digit
// outputs of the stopwatch timekeeping core.
// master: the side that produces ticks and button pulses and reads the digits.
// slave: the timekeeping core itself.
interface stopwatch_counter_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause_p;
    logic       clr_p;
    logic       adj;
    logic       sel;
    logic [2:0] min_t;
    logic [3:0] min_o;
    logic [2:0] sec_t;
    logic [3:0] sec_o;
    logic       paused;
    logic       rolled;

    modport master (
        output tick_1hz, tick_2hz, pause_p, clr_p, adj, sel,
        input  min_t, min_o, sec_t, sec_o, paused, rolled
    );

    modport slave (
        input  tick_1hz, tick_2hz, pause_p, clr_p, adj, sel,
        output min_t, min_o, sec_t, sec_o, paused, rolled
    );
endinterface

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS timekeeping core with run, halt, clear and
// per-field adjust modes. The 1 Hz and 2 Hz ticks are single-cycle enables
// on clk, never clocks.
// Optional build macro: STOPWATCH_ROLLOVER_STOP_EN -- when defined, a run-mode
// tick at 59:59 holds 59:59 and halts instead of wrapping to 00:00.
module stopwatch_counter (
    input  logic                      clk,
    input  logic                      rst_n,
    stopwatch_counter_if.slave        bus
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        ADJ  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] minTens_q, minTens_d;
    logic [3:0] minOnes_q, minOnes_d;
    logic [2:0] secTens_q, secTens_d;
    logic [3:0] secOnes_q, secOnes_d;
    logic       rolled_q, rolled_d;

    logic [6:0] secIncr;
    logic [6:0] minIncr;
    logic       secAtMax;
    logic       minAtMax;

    // Advance a two-digit 00-59 field by one; 59 wraps to 00. Out-of-range
    // digits are folded back to zero so the registers stay legal BCD.
    function automatic logic [6:0] incField(input logic [2:0] tens, input logic [3:0] ones);
        logic [2:0] tensNext;
        logic [3:0] onesNext;
        if (ones >= 4'd9) begin
            onesNext = 4'd0;
            tensNext = (tens >= 3'd5) ? 3'd0 : tens + 3'd1;
        end else begin
            onesNext = ones + 4'd1;
            tensNext = (tens > 3'd5) ? 3'd0 : tens;
        end
        return {tensNext, onesNext};
    endfunction

    // Next-state, next-digit and rollover-pulse logic, all keyed on the registered state.
    always_comb begin
        state_d   = state_q;
        minTens_d = minTens_q;
        minOnes_d = minOnes_q;
        secTens_d = secTens_q;
        secOnes_d = secOnes_q;
        rolled_d  = 1'b0;

        secIncr  = incField(secTens_q, secOnes_q);
        minIncr  = incField(minTens_q, minOnes_q);
        secAtMax = (secTens_q == 3'd5) && (secOnes_q == 4'd9);
        minAtMax = (minTens_q == 3'd5) && (minOnes_q == 4'd9);

        if (bus.clr_p) begin
            // Clear beats everything, including any tick in the same cycle.
            minTens_d = 3'd0;
            minOnes_d = 4'd0;
            secTens_d = 3'd0;
            secOnes_d = 4'd0;
            state_d   = HALT;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.tick_1hz) begin
                        if (secAtMax && minAtMax) begin
                            rolled_d = 1'b1;
                        end
`ifdef STOPWATCH_ROLLOVER_STOP_EN
                        if (secAtMax && minAtMax) begin
                            state_d = HALT;
                        end else begin
                            {secTens_d, secOnes_d} = secIncr;
                            if (secAtMax) begin
                                {minTens_d, minOnes_d} = minIncr;
                            end
                        end
`else
                        {secTens_d, secOnes_d} = secIncr;
                        if (secAtMax) begin
                            {minTens_d, minOnes_d} = minIncr;
                        end
`endif
                    end
                    if (bus.adj) begin
                        state_d = ADJ;
                    end else if (bus.pause_p) begin
                        state_d = HALT;
                    end
                end
                HALT: begin
                    if (bus.adj) begin
                        state_d = ADJ;
                    end else if (bus.pause_p) begin
                        state_d = RUN;
                    end
                end
                ADJ: begin
                    // Each field wraps on its own; adjusting never carries or pulses rolled.
                    if (bus.tick_2hz) begin
                        if (bus.sel) begin
                            {secTens_d, secOnes_d} = secIncr;
                        end else begin
                            {minTens_d, minOnes_d} = minIncr;
                        end
                    end
                    if (!bus.adj) begin
                        state_d = HALT;
                    end
                end
                default: begin
                    state_d = HALT;
                end
            endcase
        end
    end

    // State, digit and rollover registers; reset asynchronously to 00:00 running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            minTens_q <= 3'd0;
            minOnes_q <= 4'd0;
            secTens_q <= 3'd0;
            secOnes_q <= 4'd0;
            rolled_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            minTens_q <= minTens_d;
            minOnes_q <= minOnes_d;
            secTens_q <= secTens_d;
            secOnes_q <= secOnes_d;
            rolled_q  <= rolled_d;
        end
    end

    assign bus.min_t  = minTens_q;
    assign bus.min_o  = minOnes_q;
    assign bus.sec_t  = secTens_q;
    assign bus.sec_o  = secOnes_q;
    assign bus.paused = (state_q != RUN);
    assign bus.rolled = rolled_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: scoreboard-based bench for stopwatch_counter.
// Expected MM:SS/paused/rolled values are derived from an elapsed-seconds
// count and queued when stimulus is driven, then popped when sampled.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    logic rst_n;
    int   testsRun    = 0;
    int   testsFailed = 0;
    logic [15:0] expQ[$];
    logic [15:0] got;
    logic [15:0] want;

    stopwatch_counter_if swIf();

    stopwatch_counter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (swIf)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Pack {MM:SS digits, paused, rolled} from a seconds count.
    function automatic logic [15:0] mkExp(input int secs, input logic p, input logic r);
        int m = secs / 60;
        int s = secs % 60;
        return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), p, r};
    endfunction

    function automatic logic [15:0] observed();
        return {swIf.min_t, swIf.min_o, swIf.sec_t, swIf.sec_o, swIf.paused, swIf.rolled};
    endfunction

    function automatic string fmt(input logic [15:0] v);
        return $sformatf("%0d%0d:%0d%0d paused=%b rolled=%b",
                         v[15:13], v[12:9], v[8:6], v[5:2], v[1], v[0]);
    endfunction

    // Drive one cycle of inputs at the falling edge; pulses drop after one cycle.
    task automatic step(input logic t1, input logic t2, input logic pp,
                        input logic cp, input logic a, input logic s);
        swIf.tick_1hz = t1;
        swIf.tick_2hz = t2;
        swIf.pause_p  = pp;
        swIf.clr_p    = cp;
        swIf.adj      = a;
        swIf.sel      = s;
        @(negedge clk);
        swIf.tick_1hz = 1'b0;
        swIf.tick_2hz = 1'b0;
        swIf.pause_p  = 1'b0;
        swIf.clr_p    = 1'b0;
    endtask

    // Load MM:SS through adjust mode; leaves HALT, or RUN when goRun is set.
    task automatic preload(input int mm, input int ss, input bit goRun);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (mm) step(0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        repeat (ss) step(0, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        if (goRun) step(0, 0, 1, 0, 0, 1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        expQ.push_back(mkExp(0, 0, 0));
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL reset_held: got %s want %s", fmt(got), fmt(want));
        end
        rst_n = 1'b1;
        @(negedge clk);
        expQ.push_back(mkExp(0, 0, 0));
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL reset_released: got %s want %s", fmt(got), fmt(want));
        end
    endtask

    task automatic test_async_reset();
        preload(12, 34, 1);
        expQ.push_back(mkExp(754, 0, 0));
        step(1, 0, 0, 0, 0, 1);
        expQ.push_back(mkExp(755, 0, 0));
        // The first entry describes the state before the tick; skip it after sampling pre-tick.
        want = expQ.pop_front();
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL async_pre_count: got %s want %s", fmt(got), fmt(want));
        end
        #2 rst_n = 1'b0;
        expQ.push_back(mkExp(0, 0, 0));
        #1;
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_mid: got %s want %s", fmt(got), fmt(want));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0, 0, 0);
            expQ.push_back(mkExp(i, 0, 0));
            got = observed(); want = expQ.pop_front(); testsRun++;
            if (got !== want) begin
                testsFailed++;
                $display("[TB] FAIL after_reset_tick%0d: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_carry();
        preload(9, 59, 0);
        expQ.push_back(mkExp(599, 1, 0));
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL carry_preload: got %s want %s", fmt(got), fmt(want));
        end
        step(1, 0, 0, 0, 0, 0);
        expQ.push_back(mkExp(599, 1, 0));
        step(0, 0, 1, 0, 0, 0);
        expQ.push_back(mkExp(599, 0, 0));
        step(1, 0, 0, 0, 0, 0);
        expQ.push_back(mkExp(600, 0, 0));
        // Only the final value is visible now; earlier entries were pushed as the stimulus went out.
        want = expQ.pop_front();
        want = expQ.pop_front();
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL carry_chain: got %s want %s", fmt(got), fmt(want));
        end
    endtask

    task automatic test_halt_ignores_tick();
        preload(3, 10, 0);
        step(1, 0, 0, 0, 0, 0);
        expQ.push_back(mkExp(190, 1, 0));
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL halt_tick: got %s want %s", fmt(got), fmt(want));
        end
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expQ.push_back(mkExp(191, 0, 0));
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL resume_tick: got %s want %s", fmt(got), fmt(want));
        end
    endtask

    task automatic test_wrap();
        logic [15:0] seq [3];
`ifdef STOPWATCH_ROLLOVER_STOP_EN
        seq[0] = mkExp(3599, 1, 1);
        seq[1] = mkExp(3599, 1, 0);
        seq[2] = mkExp(3599, 1, 0);
`else
        seq[0] = mkExp(0, 0, 1);
        seq[1] = mkExp(0, 0, 0);
        seq[2] = mkExp(1, 0, 0);
`endif
        preload(59, 59, 1);
        expQ.push_back(mkExp(3599, 0, 0));
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL wrap_preload: got %s want %s", fmt(got), fmt(want));
        end
        for (int i = 0; i < 3; i++) begin
            step((i != 1), 0, 0, 0, 0, 0);
            expQ.push_back(seq[i]);
            got = observed(); want = expQ.pop_front(); testsRun++;
            if (got !== want) begin
                testsFailed++;
                $display("[TB] FAIL wrap_step%0d: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_adjust();
        preload(7, 58, 0);
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 1, 1);
            expQ.push_back(mkExp(420 + (59 + i) % 60, 1, 0));
            got = observed(); want = expQ.pop_front(); testsRun++;
            if (got !== want) begin
                testsFailed++;
                $display("[TB] FAIL adj_sec%0d: got %s want %s", i, fmt(got), fmt(want));
            end
            step(1, 0, 0, 0, 1, 1);
            expQ.push_back(mkExp(420 + (59 + i) % 60, 1, 0));
            got = observed(); want = expQ.pop_front(); testsRun++;
            if (got !== want) begin
                testsFailed++;
                $display("[TB] FAIL adj_ignore_1hz%0d: got %s want %s", i, fmt(got), fmt(want));
            end
        end
        step(0, 0, 1, 0, 1, 1);
        step(0, 1, 0, 0, 1, 1);
        expQ.push_back(mkExp(422, 1, 0));
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL adj_ignore_pause: got %s want %s", fmt(got), fmt(want));
        end
        preload(59, 30, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        expQ.push_back(mkExp(30, 1, 0));
        got = observed(); want = expQ.pop_front(); testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL adj_min_wrap: got %s want %s", fmt(got), fmt(want));
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        logic [15:0] seq [8];
        logic [5:0]  stim [8];
        seq[0] = mkExp(6, 1, 0);  stim[0] = 6'b101000;
        seq[1] = mkExp(6, 0, 0);  stim[1] = 6'b001000;
        seq[2] = mkExp(7, 0, 0);  stim[2] = 6'b110000;
        seq[3] = mkExp(0, 1, 0);  stim[3] = 6'b100100;
        seq[4] = mkExp(0, 0, 0);  stim[4] = 6'b001000;
        seq[5] = mkExp(1, 1, 0);  stim[5] = 6'b100011;
        seq[6] = mkExp(2, 1, 0);  stim[6] = 6'b010001;
        seq[7] = mkExp(2, 0, 0);  stim[7] = 6'b001000;
        preload(0, 5, 1);
        for (int i = 0; i < 8; i++) begin
            step(stim[i][5], stim[i][4], stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            expQ.push_back(seq[i]);
            got = observed(); want = expQ.pop_front(); testsRun++;
            if (got !== want) begin
                testsFailed++;
                $display("[TB] FAIL simul_step%0d: got %s want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    // Hard time limit so a stuck run still reports.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got incomplete run want finished run");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        swIf.tick_1hz = 1'b0;
        swIf.tick_2hz = 1'b0;
        swIf.pause_p  = 1'b0;
        swIf.clr_p    = 1'b0;
        swIf.adj      = 1'b0;
        swIf.sel      = 1'b0;
        test_reset();
        test_async_reset();
        test_carry();
        test_halt_ignores_tick();
        test_wrap();
        test_adjust();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
